// File: rtl/rt_pixel_scheduler.sv
// Raster-order pixel scheduler: issues (x,y) rays to the ray generation unit under
// credit flow control and tags returning results with their pixel coordinates.
module rt_pixel_scheduler #(
  parameter int COORD_W = 12,
  parameter int CREDITS = 8,
  parameter int FP_WL   = 32,
  parameter int FP_QW   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               abort,
  input  logic [COORD_W-1:0] img_width,
  input  logic [COORD_W-1:0] img_height,
  output logic               rgu_start,
  output logic [FP_WL-1:0]   rgu_x,
  output logic [FP_WL-1:0]   rgu_y,
  input  logic               rgu_valid,
  output logic               ray_valid,
  output logic [COORD_W-1:0] ray_px,
  output logic [COORD_W-1:0] ray_py,
  input  logic               credit_return,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_aborted,
  output logic               tag_error
);

  if (COORD_W + FP_QW >= FP_WL) begin : g_bad_fp
    $error("rt_pixel_scheduler: COORD_W+FP_QW must be less than FP_WL");
  end
  if (CREDITS < 1 || CREDITS > 16) begin : g_bad_credits
    $error("rt_pixel_scheduler: CREDITS must be within 1..16");
  end

  localparam int         DEPTH     = 16;
  localparam int         CRW       = 5;
  localparam logic [4:0] FIFO_FULL = 5'd16;
  localparam logic [CRW-1:0] CRED_MAX = CRW'(CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [COORD_W-1:0]   x, y, width, height;
  logic [CRW-1:0]       credits, credits_nxt;
  logic                 abort_flag;
  logic [2*COORD_W-1:0] tag_mem [DEPTH];
  logic [3:0]           wr_ptr, rd_ptr;
  logic [4:0]           tag_count;
  logic                 issue, last_pixel, push, pop, underflow, overflow, accept;
  logic [FP_WL-1:0]     x_fp, y_fp;

  assign last_pixel = (x == width - 1'b1) && (y == height - 1'b1);
  assign accept     = (state == IDLE) && frame_start;
  assign push       = issue && !(tag_count == FIFO_FULL);
  assign pop        = rgu_valid && (tag_count != 5'd0);
  assign underflow  = rgu_valid && (tag_count == 5'd0);
  assign overflow   = issue && (tag_count == FIFO_FULL);
  assign x_fp       = FP_WL'(x) << FP_QW;
  assign y_fp       = FP_WL'(y) << FP_QW;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          if (img_width != '0 && img_height != '0) state_nxt = RUN;
          else                                     state_nxt = DONE;
        end
      end
      RUN: begin
        // abort takes priority over any issue, including the final pixel
        if (abort) begin
          state_nxt = DRAIN;
        end else if (credits != '0) begin
          issue = 1'b1;
          if (last_pixel) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_count == 5'd0 && !pop && !push) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    credits_nxt = credits;
    case ({issue, credit_return})
      2'b10:   credits_nxt = credits - 1'b1;
      2'b01:   credits_nxt = (credits == CRED_MAX) ? credits : credits + 1'b1;
      default: credits_nxt = credits;
    endcase
    if (accept && tag_count == 5'd0) credits_nxt = CRED_MAX;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      width      <= '0;
      height     <= '0;
      credits    <= CRED_MAX;
      abort_flag <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      tag_error  <= 1'b0;
      rgu_start  <= 1'b0;
      rgu_x      <= '0;
      rgu_y      <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      state     <= state_nxt;
      credits   <= credits_nxt;
      rgu_start <= issue;
      tag_error <= tag_error | underflow | overflow;

      if (accept) begin
        width      <= img_width;
        height     <= img_height;
        x          <= '0;
        y          <= '0;
        abort_flag <= 1'b0;
      end else if (issue) begin
        rgu_x <= x_fp;
        rgu_y <= y_fp;
        if (x == width - 1'b1) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end

      if ((state == RUN || state == DRAIN) && abort) abort_flag <= 1'b1;
      else if (state == DONE)                        abort_flag <= 1'b0;

      if (push) begin
        tag_mem[wr_ptr] <= {x, y};
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      tag_count <= tag_count + {4'd0, push} - {4'd0, pop};
    end
  end

  assign {ray_px, ray_py} = tag_mem[rd_ptr];
  assign ray_valid        = rgu_valid;
  assign busy             = (state != IDLE);
  assign frame_done       = (state == DONE) && !abort_flag;
  assign frame_aborted    = (state == DONE) && abort_flag;

endmodule

// File: tb/tb_rt_pixel_scheduler.sv
// Directed bench for rt_pixel_scheduler with a 5-cycle ray generation unit model
// and optional credit return tied to each emitted ray.
module tb_rt_pixel_scheduler;
  localparam int COORD_W = 12;
  localparam int CREDITS = 8;
  localparam int FP_WL   = 32;
  localparam int FP_QW   = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_start = 1'b0;
  logic               abort = 1'b0;
  logic [COORD_W-1:0] img_width = '0;
  logic [COORD_W-1:0] img_height = '0;
  logic               rgu_valid = 1'b0;
  logic               credit_return = 1'b0;
  logic               rgu_start, ray_valid, busy, frame_done, frame_aborted, tag_error;
  logic [FP_WL-1:0]   rgu_x, rgu_y;
  logic [COORD_W-1:0] ray_px, ray_py;

  rt_pixel_scheduler #(
    .COORD_W(COORD_W), .CREDITS(CREDITS), .FP_WL(FP_WL), .FP_QW(FP_QW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort),
    .img_width(img_width), .img_height(img_height),
    .rgu_start(rgu_start), .rgu_x(rgu_x), .rgu_y(rgu_y), .rgu_valid(rgu_valid),
    .ray_valid(ray_valid), .ray_px(ray_px), .ray_py(ray_py),
    .credit_return(credit_return), .busy(busy), .frame_done(frame_done),
    .frame_aborted(frame_aborted), .tag_error(tag_error)
  );

  always #5 clk = ~clk;

  int   nAssert = 0;
  int   nFail = 0;
  bit   tieCredit = 1'b0;
  bit   injValid = 1'b0;
  bit   pulseCredit = 1'b0;
  logic [5:0] rguHist = '0;
  int   nStart, nRay, nDone, nAborted, rayAtDone;
  int   startX[$], startY[$], rayX[$], rayY[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nAssert++;
    if (observed != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // one clock cycle: record registered outputs, advance the RGU model, record rays
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (rgu_start) begin
      nStart++;
      startX.push_back(int'(rgu_x));
      startY.push_back(int'(rgu_y));
    end
    if (frame_done) begin
      nDone++;
      rayAtDone = nRay;
    end
    if (frame_aborted) nAborted++;
    rguHist       = {rguHist[4:0], rgu_start};
    rgu_valid     = rguHist[5] | injValid;
    injValid      = 1'b0;
    credit_return = (tieCredit & rgu_valid) | pulseCredit;
    pulseCredit   = 1'b0;
    #1;
    if (ray_valid) begin
      nRay++;
      rayX.push_back(int'(ray_px));
      rayY.push_back(int'(ray_py));
    end
  endtask

  task automatic resetCounters();
    nStart = 0; nRay = 0; nDone = 0; nAborted = 0; rayAtDone = -1;
    startX.delete(); startY.delete(); rayX.delete(); rayY.delete();
  endtask

  task automatic clearModel();
    rguHist = '0; rgu_valid = 1'b0; credit_return = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    clearModel();
  endtask

  task automatic startFrame(input int w, input int h);
    img_width   = COORD_W'(w);
    img_height  = COORD_W'(h);
    frame_start = 1'b1;
    applyStimulus();
    frame_start = 1'b0;
  endtask

  task automatic waitFrameEnd(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (nDone + nAborted > 0) break;
      applyStimulus();
    end
  endtask

  task automatic waitStarts(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (nStart >= n) break;
      applyStimulus();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expX[6];
    int expY[6];
    expX = '{0, 1, 2, 0, 1, 2};
    expY = '{0, 0, 0, 1, 1, 1};

    resetCounters();
    applyReset();
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_rgu_start", int'(rgu_start), 0);
    checkOutput("reset_frame_done", int'(frame_done), 0);
    checkOutput("reset_frame_aborted", int'(frame_aborted), 0);
    checkOutput("reset_tag_error", int'(tag_error), 0);

    // 3x2 frame, credits returned with each ray
    $display("[TB] 3x2 raster frame");
    resetCounters();
    tieCredit = 1'b1;
    startFrame(3, 2);
    waitFrameEnd(200);
    repeat (5) applyStimulus();
    checkOutput("f1_starts", nStart, 6);
    checkOutput("f1_rays", nRay, 6);
    checkOutput("f1_done_count", nDone, 1);
    checkOutput("f1_aborted_count", nAborted, 0);
    checkOutput("f1_rays_before_done", rayAtDone, 6);
    for (int i = 0; i < 6 && i < startX.size(); i++) begin
      checkOutput($sformatf("f1_rgu_x%0d", i), startX[i], expX[i] << FP_QW);
      checkOutput($sformatf("f1_rgu_y%0d", i), startY[i], expY[i] << FP_QW);
    end
    for (int i = 0; i < 6 && i < rayX.size(); i++) begin
      checkOutput($sformatf("f1_ray_px%0d", i), rayX[i], expX[i]);
      checkOutput($sformatf("f1_ray_py%0d", i), rayY[i], expY[i]);
    end
    checkOutput("f1_idle_busy", int'(busy), 0);

    // 4x4 frame without credit return: stalls after CREDITS issues
    $display("[TB] credit stall");
    resetCounters();
    tieCredit = 1'b0;
    startFrame(4, 4);
    repeat (40) applyStimulus();
    checkOutput("stall_starts", nStart, 8);
    checkOutput("stall_rays", nRay, 8);
    checkOutput("stall_busy", int'(busy), 1);
    pulseCredit = 1'b1;
    repeat (20) applyStimulus();
    checkOutput("one_credit_starts", nStart, 9);
    applyReset();

    // abort after the third issue
    $display("[TB] abort mid-frame");
    resetCounters();
    tieCredit = 1'b1;
    startFrame(4, 4);
    waitStarts(3, 50);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    waitFrameEnd(100);
    checkOutput("abort_pulse", int'(frame_aborted), 1);
    checkOutput("abort_busy_in_done", int'(busy), 1);
    applyStimulus();
    checkOutput("abort_busy_after", int'(busy), 0);
    repeat (10) applyStimulus();
    checkOutput("abort_starts", nStart, 3);
    checkOutput("abort_rays", nRay, 3);
    checkOutput("abort_aborted_count", nAborted, 1);
    checkOutput("abort_done_count", nDone, 0);

    // zero-width frame completes immediately
    $display("[TB] zero-width frame");
    resetCounters();
    startFrame(0, 5);
    checkOutput("zero_busy", int'(busy), 1);
    checkOutput("zero_done", int'(frame_done), 1);
    applyStimulus();
    checkOutput("zero_busy_after", int'(busy), 0);
    checkOutput("zero_done_after", int'(frame_done), 0);
    repeat (3) applyStimulus();
    checkOutput("zero_starts", nStart, 0);
    checkOutput("zero_done_count", nDone, 1);

    // reset with rays in flight, then a fresh 2x1 frame
    $display("[TB] reset mid-frame");
    resetCounters();
    tieCredit = 1'b1;
    startFrame(4, 4);
    waitStarts(5, 50);
    reset = 1'b1;
    applyStimulus();
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_rgu_start", int'(rgu_start), 0);
    checkOutput("midreset_tag_error", int'(tag_error), 0);
    applyStimulus();
    reset = 1'b0;
    clearModel();
    resetCounters();
    startFrame(2, 1);
    waitFrameEnd(100);
    repeat (3) applyStimulus();
    checkOutput("post_reset_starts", nStart, 2);
    checkOutput("post_reset_rays", nRay, 2);
    checkOutput("post_reset_done", nDone, 1);
    for (int i = 0; i < 2 && i < rayX.size(); i++) begin
      checkOutput($sformatf("post_reset_ray_px%0d", i), rayX[i], i);
      checkOutput($sformatf("post_reset_ray_py%0d", i), rayY[i], 0);
    end
    checkOutput("post_reset_tag_error", int'(tag_error), 0);

    // stray rgu_valid while idle raises a sticky tag error
    $display("[TB] stray result in IDLE");
    resetCounters();
    tieCredit = 1'b0;
    injValid  = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("stray_tag_error", int'(tag_error), 1);
    repeat (5) applyStimulus();
    checkOutput("stray_tag_error_sticky", int'(tag_error), 1);
    checkOutput("stray_busy", int'(busy), 0);
    applyReset();
    checkOutput("stray_cleared_by_reset", int'(tag_error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
